// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter family: parity encodings,
// serialiser state codes and the baud divisor helper.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   function automatic int uart_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous input FIFO for the UART transmitter; pointers carry one extra
// wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_wr == r_rd);
   assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push_ok) r_wr <= r_wr + 1'b1;
         if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter (5-9 data bits, none/odd/even parity, 1-2 stop bits).
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the serialiser.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 12000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 busy,
   output logic                 uart_tx
);

   localparam int DIV = uart_div(CLK_HZ, BAUD);
   localparam int CW  = $clog2(DIV);
   localparam int BW  = $clog2(DATA_BITS);

   if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("uart_tx_frame: illegal parameter set");
   end

   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      return (PARITY == PARITY_ODD) ? ~^d : ^d;
   endfunction

   logic [2:0]           r_state;
   logic [CW-1:0]        r_baud;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_tx;
   logic                 r_alive;
   logic                 w_bit_end;
   logic                 w_last_data;
   logic                 w_last_stop;
   logic                 w_slot;
   logic                 w_load;
   logic                 w_shift;
   logic [DATA_BITS-1:0] w_word;

   assign w_bit_end   = (r_baud == CW'(DIV - 1));
   assign w_last_data = (r_bit == BW'(DATA_BITS - 1));
   assign w_last_stop = (r_state == ST_STOP) && w_bit_end && (r_bit == BW'(STOP_BITS - 1));
   // A new word may start in IDLE or exactly on the edge that closes the last stop bit.
   assign w_slot      = r_alive && ((r_state == ST_IDLE) || w_last_stop);
   assign w_shift     = w_bit_end && ((r_state == ST_START) ||
                                      ((r_state == ST_DATA) && !w_last_data));

`ifdef UART_TX_FIFO_EN
   logic                 w_full;
   logic                 w_empty;
   logic [DATA_BITS-1:0] w_fifo_q;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (CLOCK),
      .i_rst   (RESET),
      .i_push  (tx_valid && tx_ready),
      .i_data  (tx_data),
      .i_pop   (w_load),
      .o_data  (w_fifo_q),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign tx_ready = r_alive && !w_full;
   assign w_load   = w_slot && !w_empty;
   assign w_word   = w_fifo_q;
   assign busy     = (r_state != ST_IDLE) || !w_empty;
`else
   assign tx_ready = w_slot;
   assign w_load   = tx_valid && w_slot;
   assign w_word   = tx_data;
   assign busy     = (r_state != ST_IDLE);
`endif

   assign uart_tx = r_tx;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_tx    <= 1'b1;
         r_alive <= 1'b0;
      end else begin
         r_alive <= 1'b1;
         if (w_load) begin
            r_state <= ST_START;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
         end else if (r_state == ST_IDLE) begin
            r_baud <= '0;
            r_tx   <= 1'b1;
         end else if (!w_bit_end) begin
            r_baud <= r_baud + 1'b1;
         end else begin
            r_baud <= '0;
            case (r_state)
               ST_START: begin
                  r_state <= ST_DATA;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
               end
               ST_DATA: begin
                  if (w_last_data) begin
                     r_bit <= '0;
                     if (PARITY != PARITY_NONE) begin
                        r_state <= ST_PARITY;
                        r_tx    <= r_par;
                     end else begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_bit <= r_bit + 1'b1;
                     r_tx  <= r_shift[0];
                  end
               end
               ST_PARITY: begin
                  r_state <= ST_STOP;
                  r_bit   <= '0;
                  r_tx    <= 1'b1;
               end
               ST_STOP: begin
                  if (r_bit == BW'(STOP_BITS - 1)) begin
                     r_state <= ST_IDLE;
                     r_bit   <= '0;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_bit   <= '0;
                  r_tx    <= 1'b1;
               end
            endcase
         end
      end
   end

   // Word and parity are frozen at load so later tx_data changes cannot disturb the frame.
   always_ff @(posedge CLOCK) begin
      if (w_load) begin
         r_shift <= w_word;
         r_par   <= parity_bit(w_word);
      end else if (w_shift) begin
         r_shift <= r_shift >> 1;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: 8N1, 7E2 and 7O2 instances at DIV=8,
// compared per clock against a frame model built from the line format rules.
module tb_uart_tx_frame;

   localparam int DIV = 8;
`ifdef UART_TX_FIFO_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic       CLOCK = 1'b0;
   logic       rst_a = 1'b1;
   logic       rst_bc = 1'b1;
   logic [7:0] d_a = '0;
   logic       v_a = 1'b0;
   logic       rdy_a, busy_a, tx_a;
   logic [6:0] d_bc = '0;
   logic       v_bc = 1'b0;
   logic       rdy_b, busy_b, tx_b;
   logic       rdy_c, busy_c, tx_c;

   int n_chk  = 0;
   int n_fail = 0;

   bit obs_tx[$];
   bit obs_busy[$];
   bit obs_tx2[$];
   bit obs_busy2[$];

   uart_tx_frame #(.CLK_HZ(800), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .FIFO_DEPTH(4)) u_8n1 (
      .CLOCK(CLOCK), .RESET(rst_a), .tx_data(d_a), .tx_valid(v_a),
      .tx_ready(rdy_a), .busy(busy_a), .uart_tx(tx_a));

   uart_tx_frame #(.CLK_HZ(800), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                   .FIFO_DEPTH(4)) u_7e2 (
      .CLOCK(CLOCK), .RESET(rst_bc), .tx_data(d_bc), .tx_valid(v_bc),
      .tx_ready(rdy_b), .busy(busy_b), .uart_tx(tx_b));

   uart_tx_frame #(.CLK_HZ(800), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
                   .FIFO_DEPTH(4)) u_7o2 (
      .CLOCK(CLOCK), .RESET(rst_bc), .tx_data(d_bc), .tx_valid(v_bc),
      .tx_ready(rdy_c), .busy(busy_c), .uart_tx(tx_c));

   initial forever #5 CLOCK = ~CLOCK;

   // Reference frame: start 0, data LSB first, optional parity, then stop ones.
   function automatic int frame_len(input int nbits, input int par, input int stops);
      return 1 + nbits + ((par != 0) ? 1 : 0) + stops;
   endfunction

   function automatic bit frame_bit(input int unsigned data, input int nbits, input int par,
                                    input int idx);
      int unsigned masked;
      int ones;
      masked = data & ((32'd1 << nbits) - 1);
      ones   = $countones(masked);
      if (idx == 0) return 1'b0;
      if (idx <= nbits) return masked[idx-1];
      if (par == 2 && idx == nbits + 1) return (ones % 2) == 1;
      if (par == 1 && idx == nbits + 1) return (ones % 2) == 0;
      return 1'b1;
   endfunction

   task automatic cap_a(input int n);
      obs_tx.delete();
      obs_busy.delete();
      repeat (n) begin
         @(negedge CLOCK);
         obs_tx.push_back(tx_a);
         obs_busy.push_back(busy_a);
      end
   endtask

   task automatic cap_bc(input int n);
      obs_tx.delete();
      obs_busy.delete();
      obs_tx2.delete();
      obs_busy2.delete();
      repeat (n) begin
         @(negedge CLOCK);
         obs_tx.push_back(tx_b);
         obs_busy.push_back(busy_b);
         obs_tx2.push_back(tx_c);
         obs_busy2.push_back(busy_c);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLOCK);
      @(negedge CLOCK);
      n_chk++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || rdy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: tx/busy/ready got %b%b%b want 100", tx_a, busy_a, rdy_a);
      end
      n_chk++;
      if (tx_b !== 1'b1 || rdy_b !== 1'b0 || rdy_c !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold_bc: tx_b/rdy_b/rdy_c got %b%b%b want 100", tx_b, rdy_b, rdy_c);
      end
      rst_a  = 1'b0;
      rst_bc = 1'b0;
      #1;
      n_chk++;
      if (rdy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_before_edge: got %b want 0", rdy_a);
      end
      @(negedge CLOCK);
      n_chk++;
      if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_after_release: rdy_a/rdy_b/tx/busy got %b%b%b%b want 1110",
                  rdy_a, rdy_b, tx_a, busy_a);
      end
   endtask

   task automatic test_8n1();
      logic [7:0] w [4];
      int fl;
      fl = frame_len(8, 0, 1) * DIV;
      w[0] = 8'hA5;
      for (int i = 1; i < 4; i++) w[i] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
         @(negedge CLOCK);
         n_chk++;
         if (rdy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL 8n1_ready_idle: got %b want 1", rdy_a);
         end
         d_a = w[k];
         v_a = 1'b1;
         @(posedge CLOCK);
         #1 v_a = 1'b0;
         d_a = 8'($urandom);
         cap_a(LAT + fl + 1);
         for (int j = 0; j < fl; j++) begin
            n_chk++;
            if (obs_tx[LAT+j] !== frame_bit(w[k], 8, 0, j / DIV) || obs_busy[LAT+j] !== 1'b1) begin
               n_fail++;
               $display("FAIL 8n1_line word=%h clk=%0d: tx/busy got %b%b want %b1", w[k], j,
                        obs_tx[LAT+j], obs_busy[LAT+j], frame_bit(w[k], 8, 0, j / DIV));
            end
         end
         n_chk++;
         if (obs_tx[LAT+fl] !== 1'b1 || obs_busy[LAT+fl] !== 1'b0) begin
            n_fail++;
            $display("FAIL 8n1_end word=%h: tx/busy got %b%b want 10", w[k],
                     obs_tx[LAT+fl], obs_busy[LAT+fl]);
         end
      end
   endtask

   task automatic test_parity();
      logic [6:0] w [3];
      int fl;
      fl = frame_len(7, 2, 2) * DIV;
      w[0] = 7'h35;
      for (int i = 1; i < 3; i++) w[i] = 7'($urandom_range(0, 127));
      for (int k = 0; k < 3; k++) begin
         @(negedge CLOCK);
         d_bc = w[k];
         v_bc = 1'b1;
         @(posedge CLOCK);
         #1 v_bc = 1'b0;
         d_bc = 7'($urandom);
         cap_bc(LAT + fl + 1);
         for (int j = 0; j < fl; j++) begin
            n_chk++;
            if (obs_tx[LAT+j] !== frame_bit(w[k], 7, 2, j / DIV) || obs_busy[LAT+j] !== 1'b1) begin
               n_fail++;
               $display("FAIL 7e2_line word=%h clk=%0d: tx/busy got %b%b want %b1", w[k], j,
                        obs_tx[LAT+j], obs_busy[LAT+j], frame_bit(w[k], 7, 2, j / DIV));
            end
            n_chk++;
            if (obs_tx2[LAT+j] !== frame_bit(w[k], 7, 1, j / DIV) || obs_busy2[LAT+j] !== 1'b1) begin
               n_fail++;
               $display("FAIL 7o2_line word=%h clk=%0d: tx/busy got %b%b want %b1", w[k], j,
                        obs_tx2[LAT+j], obs_busy2[LAT+j], frame_bit(w[k], 7, 1, j / DIV));
            end
         end
         n_chk++;
         if (obs_busy[LAT+fl] !== 1'b0 || obs_busy2[LAT+fl] !== 1'b0 ||
             obs_tx[LAT+fl] !== 1'b1 || obs_tx2[LAT+fl] !== 1'b1) begin
            n_fail++;
            $display("FAIL 7x2_end word=%h: busy_e/busy_o/tx_e/tx_o got %b%b%b%b want 0011", w[k],
                     obs_busy[LAT+fl], obs_busy2[LAT+fl], obs_tx[LAT+fl], obs_tx2[LAT+fl]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int fl;
      int hold;
      logic [7:0] w0;
      logic [7:0] w1;
      fl   = frame_len(8, 0, 1) * DIV;
      hold = (LAT != 0) ? 1 : fl;
      w0   = 8'h00;
      w1   = 8'hFF;
      @(negedge CLOCK);
      d_a = w0;
      v_a = 1'b1;
      @(posedge CLOCK);
      #1 d_a = w1;
      fork
         cap_a(LAT + 2 * fl + 1);
         begin
            repeat (hold) @(posedge CLOCK);
            #1 v_a = 1'b0;
         end
      join
      for (int j = 0; j < 2 * fl; j++) begin
         n_chk++;
         if (obs_tx[LAT+j] !== ((j < fl) ? frame_bit(w0, 8, 0, j / DIV)
                                         : frame_bit(w1, 8, 0, (j - fl) / DIV)) ||
             obs_busy[LAT+j] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_line clk=%0d: tx/busy got %b%b", j, obs_tx[LAT+j], obs_busy[LAT+j]);
         end
      end
      n_chk++;
      if (obs_tx[LAT+2*fl] !== 1'b1 || obs_busy[LAT+2*fl] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: tx/busy got %b%b want 10", obs_tx[LAT+2*fl], obs_busy[LAT+2*fl]);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] w;
      int fl;
      fl = frame_len(8, 0, 1) * DIV;
      w  = 8'($urandom) & 8'hF7;
      @(negedge CLOCK);
      d_a = w;
      v_a = 1'b1;
      @(posedge CLOCK);
      #1 v_a = 1'b0;
      repeat (4 * DIV + 3) @(posedge CLOCK);
      #2;
      n_chk++;
      if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_bit3: tx/busy got %b%b want 01", tx_a, busy_a);
      end
      rst_a = 1'b1;
      #1;
      n_chk++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || rdy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL midframe_async: tx/busy/ready got %b%b%b want 100", tx_a, busy_a, rdy_a);
      end
      @(negedge CLOCK);
      @(negedge CLOCK);
      rst_a = 1'b0;
      cap_a(3 * DIV);
      for (int j = 0; j < 3 * DIV; j++) begin
         n_chk++;
         if (obs_tx[j] !== 1'b1 || obs_busy[j] !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_quiet clk=%0d: tx/busy got %b%b want 10", j, obs_tx[j], obs_busy[j]);
         end
      end
      w = 8'($urandom);
      @(negedge CLOCK);
      n_chk++;
      if (rdy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_ready: got %b want 1", rdy_a);
      end
      d_a = w;
      v_a = 1'b1;
      @(posedge CLOCK);
      #1 v_a = 1'b0;
      cap_a(LAT + fl + 1);
      for (int j = 0; j < fl; j++) begin
         n_chk++;
         if (obs_tx[LAT+j] !== frame_bit(w, 8, 0, j / DIV) || obs_busy[LAT+j] !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_resend word=%h clk=%0d: tx/busy got %b%b want %b1", w, j,
                     obs_tx[LAT+j], obs_busy[LAT+j], frame_bit(w, 8, 0, j / DIV));
         end
      end
      n_chk++;
      if (obs_busy[LAT+fl] !== 1'b0) begin
         n_fail++;
         $display("FAIL midframe_resend_end: busy got %b want 0", obs_busy[LAT+fl]);
      end
   endtask

`ifdef UART_TX_FIFO_EN
   task automatic test_fifo();
      logic [7:0] w [5];
      int fl;
      fl = frame_len(8, 0, 1) * DIV;
      for (int i = 0; i < 5; i++) w[i] = 8'($urandom_range(0, 255));
      @(negedge CLOCK);
      n_chk++;
      if (rdy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL fifo_ready_start: got %b want 1", rdy_a);
      end
      d_a = w[0];
      v_a = 1'b1;
      fork
         cap_a(LAT + 5 * fl + 1);
         begin
            @(posedge CLOCK);
            for (int i = 1; i < 5; i++) begin
               #1 d_a = w[i];
               @(negedge CLOCK);
               n_chk++;
               if (rdy_a !== 1'b1) begin
                  n_fail++;
                  $display("FAIL fifo_ready_push%0d: got %b want 1", i, rdy_a);
               end
               @(posedge CLOCK);
            end
            #1 v_a = 1'b0;
            @(negedge CLOCK);
            n_chk++;
            if (rdy_a !== 1'b0 || busy_a !== 1'b1) begin
               n_fail++;
               $display("FAIL fifo_full: ready/busy got %b%b want 01", rdy_a, busy_a);
            end
         end
      join
      for (int j = 0; j < 5 * fl; j++) begin
         n_chk++;
         if (obs_tx[LAT+j] !== frame_bit(w[j / fl], 8, 0, (j % fl) / DIV) ||
             obs_busy[LAT+j] !== 1'b1) begin
            n_fail++;
            $display("FAIL fifo_line clk=%0d: tx/busy got %b%b want %b1", j, obs_tx[LAT+j],
                     obs_busy[LAT+j], frame_bit(w[j / fl], 8, 0, (j % fl) / DIV));
         end
      end
      n_chk++;
      if (obs_busy[LAT+5*fl] !== 1'b0 || obs_tx[LAT+5*fl] !== 1'b1) begin
         n_fail++;
         $display("FAIL fifo_end: tx/busy got %b%b want 10", obs_tx[LAT+5*fl], obs_busy[LAT+5*fl]);
      end
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_reset_midframe();
`ifdef UART_TX_FIFO_EN
      test_fifo();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
